// File: rtl/fp_sub_seq.sv
// Sequential single-precision subtractor: result = A - B.
// Align, add/subtract, then one normalise shift per cycle.
module fp_sub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   invalid
);

  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);
  localparam logic [EXP_W-1:0] SH_MAX  = EXP_W'(MAN_W + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ALIGN, S_ARITH, S_NORM, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic             sign_q, sign_d;
  logic             sub_q, sub_d;
  logic             special_q, special_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [EXP_W-1:0] diff_q, diff_d;
  logic [MAN_W:0]   big_q, big_d;
  logic [MAN_W:0]   small_q, small_d;
  logic [MAN_W+1:0] man_q, man_d;
  logic [W-1:0]     result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             inv_q, inv_d;

  logic [EXP_W-1:0] ea, eb, exp_inc;
  logic             za, zb, a_ge;
  logic [MAN_W:0]   ma, mb;
  logic [W-2:0]     ka, kb;

  // Zero-exponent operands count as exact zero for magnitude ordering
  always_comb begin
    ea   = A[MAN_W +: EXP_W];
    eb   = B[MAN_W +: EXP_W];
    za   = (ea == '0);
    zb   = (eb == '0);
    ma   = za ? '0 : {1'b1, A[MAN_W-1:0]};
    mb   = zb ? '0 : {1'b1, B[MAN_W-1:0]};
    ka   = za ? '0 : A[W-2:0];
    kb   = zb ? '0 : B[W-2:0];
    a_ge = (ka >= kb);
    exp_inc = exp_q + EXP_ONE;
  end

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    sub_d     = sub_q;
    special_d = special_q;
    exp_d     = exp_q;
    diff_d    = diff_q;
    big_d     = big_q;
    small_d   = small_q;
    man_d     = man_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    inv_d     = inv_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          special_d = (ea == EXP_MAX) || (eb == EXP_MAX);
          sub_d     = (A[W-1] == B[W-1]);
          ovf_d     = 1'b0;
          inv_d     = 1'b0;
          if (a_ge) begin
            sign_d  = A[W-1];
            exp_d   = ea;
            big_d   = ma;
            small_d = mb;
            diff_d  = ea - eb;
          end else begin
            sign_d  = ~B[W-1];
            exp_d   = eb;
            big_d   = mb;
            small_d = ma;
            diff_d  = eb - ea;
          end
          state_d = S_ALIGN;
        end
      end
      S_ALIGN: begin
        small_d = (diff_q >= SH_MAX) ? '0 : (small_q >> diff_q);
        state_d = S_ARITH;
      end
      S_ARITH: begin
        man_d = sub_q ? ({1'b0, big_q} - {1'b0, small_q})
                      : ({1'b0, big_q} + {1'b0, small_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        if (special_q) begin
          result_d = {1'b0, EXP_MAX, 1'b1, {(MAN_W-1){1'b0}}};
          inv_d    = 1'b1;
          state_d  = S_DONE;
        end else if (man_q[MAN_W+1]) begin
          if (exp_inc == EXP_MAX) begin
            result_d = {sign_q, EXP_MAX, {MAN_W{1'b0}}};
            ovf_d    = 1'b1;
          end else begin
            result_d = {sign_q, exp_inc, man_q[MAN_W:1]};
          end
          state_d = S_DONE;
        end else if (man_q == '0) begin
          result_d = '0;
          state_d  = S_DONE;
        end else if (man_q[MAN_W]) begin
          result_d = {sign_q, exp_q, man_q[MAN_W-1:0]};
          state_d  = S_DONE;
        end else if (exp_q == EXP_ONE) begin
          // Further shifting would need a denormal: flush
          result_d = '0;
          state_d  = S_DONE;
        end else begin
          man_d = man_q << 1;
          exp_d = exp_q - EXP_ONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      sub_q     <= 1'b0;
      special_q <= 1'b0;
      exp_q     <= '0;
      diff_q    <= '0;
      big_q     <= '0;
      small_q   <= '0;
      man_q     <= '0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      sub_q     <= sub_d;
      special_q <= special_d;
      exp_q     <= exp_d;
      diff_q    <= diff_d;
      big_q     <= big_d;
      small_q   <= small_d;
      man_q     <= man_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      inv_q     <= inv_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign invalid   = inv_q;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Bench for fp_sub_seq: arithmetic model of A - B with
// truncating alignment, checked every cycle against the DUT.
module tb_fp_sub_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A, B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        invalid;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_sub_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .invalid(invalid)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Value-level model: magnitudes as integers, align, add/sub,
  // find leading one, renormalise exponent.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov,
                                output logic inv, output int k);
    int ea, eb, ebig, esm, d, p, sh, e;
    logic [24:0] mbig, msm, rv, t;
    logic sign, sub, a_big;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    r = '0; ov = 1'b0; inv = 1'b0; k = 0;
    if (ea == 255 || eb == 255) begin
      r = 32'h7FC00000;
      inv = 1'b1;
      return;
    end
    a_big = ((ea == 0) ? 31'd0 : a[30:0]) >= ((eb == 0) ? 31'd0 : b[30:0]);
    sign = a_big ? a[31] : ~b[31];
    sub = (a[31] == b[31]);
    if (a_big) begin
      ebig = ea; esm = eb;
      mbig = (ea == 0) ? 25'd0 : {2'b01, a[22:0]};
      msm  = (eb == 0) ? 25'd0 : {2'b01, b[22:0]};
    end else begin
      ebig = eb; esm = ea;
      mbig = (eb == 0) ? 25'd0 : {2'b01, b[22:0]};
      msm  = (ea == 0) ? 25'd0 : {2'b01, a[22:0]};
    end
    d = ebig - esm;
    if (d >= 24) msm = '0;
    else msm = msm >> d;
    rv = sub ? (mbig - msm) : (mbig + msm);
    if (rv == '0) return;
    p = 0;
    for (int i = 0; i < 25; i++) if (rv[i]) p = i;
    if (p == 24) begin
      e = ebig + 1;
      if (e == 255) begin
        r = {sign, 8'hFF, 23'd0};
        ov = 1'b1;
      end else begin
        t = rv >> 1;
        r = {sign, 8'(e), t[22:0]};
      end
    end else begin
      sh = 23 - p;
      if (ebig - sh >= 1) begin
        t = rv << sh;
        r = {sign, 8'(ebig - sh), t[22:0]};
        k = sh;
      end else begin
        r = '0;
        k = ebig - 1;
      end
    end
  endfunction

  // Compare process: tracks the outstanding operation
  logic        busy = 1'b0;
  logic        seen = 1'b0;
  int          cyc = 0;
  logic [31:0] e_r;
  logic        e_ov, e_inv;
  int          e_k;

  always @(negedge clk) begin
    logic b0;
    if (rst) begin
      busy = 1'b0;
      seen = 1'b0;
    end else begin
      if (busy) cyc++;
      b0 = busy;
      chk("in_ready", 32'(in_ready), 32'(!b0));
      if (!b0) chk("out_valid_idle", 32'(out_valid), 32'd0);
      if (b0 && out_valid) begin
        if (!seen) chk("latency", 32'(cyc), 32'(4 + e_k));
        seen = 1'b1;
        chk("result", result, e_r);
        chk("overflow", 32'(overflow), 32'(e_ov));
        chk("invalid", 32'(invalid), 32'(e_inv));
        if (out_ready) busy = 1'b0;
      end else if (b0 && cyc > 80) begin
        chk("out_valid_timeout", 32'(out_valid), 32'd1);
        busy = 1'b0;
      end
      if (!b0 && in_valid) begin
        model(A, B, e_r, e_ov, e_inv, e_k);
        busy = 1'b1;
        seen = 1'b0;
        cyc = 0;
      end
    end
  end

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic eov,
                     input logic einv, input int ek, input logic hold);
    logic [31:0] r;
    logic ov, inv;
    int k, n;
    model(a, b, r, ov, inv, k);
    chk("model_result", r, er);
    chk("model_flags", {30'd0, ov, inv}, {30'd0, eov, einv});
    chk("model_shifts", 32'(k), 32'(ek));
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    A = a;
    B = b;
    in_valid = 1'b1;
    out_ready = !hold;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!out_valid) chk("run_timeout", 32'(out_valid), 32'd1);
    if (hold) begin
      repeat (10) @(posedge clk);
      #1;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_result", result, 32'd0);
    chk("reset_flags", {30'd0, overflow, invalid}, 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);

    run(32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 0, 0);
    run(32'h3F800000, 32'h3F800000, 32'h00000000, 0, 0, 0, 0);
    run(32'h3FC00000, 32'h3F800000, 32'h3F000000, 0, 0, 1, 0);
    run(32'h3F800000, 32'hBF800000, 32'h40000000, 0, 0, 0, 0);
    run(32'h3F800000, 32'h3FC00000, 32'hBF000000, 0, 0, 1, 0);
    run(32'h4B800000, 32'h3F800000, 32'h4B800000, 0, 0, 0, 0);
    run(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000, 1, 0, 0, 0);
    run(32'h7F800000, 32'h3F800000, 32'h7FC00000, 0, 1, 0, 0);
    run(32'h3F800000, 32'h7F800000, 32'h7FC00000, 0, 1, 0, 0);
    run(32'h00000000, 32'h3F800000, 32'hBF800000, 0, 0, 0, 0);
    run(32'h3F800001, 32'h3F800000, 32'h34000000, 0, 0, 23, 0);
    run(32'h00800001, 32'h00800000, 32'h00000000, 0, 0, 0, 0);
    run(32'hC0400000, 32'hC0400000, 32'h00000000, 0, 0, 0, 0);
    run(32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 0, 1);

    // Abort a long normalisation with reset
    A = 32'h3F800001;
    B = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_output", 32'(out_valid), 32'd0);

    run(32'hBFC00000, 32'hBF800000, 32'hBF000000, 0, 0, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
